// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder (with its combinational core FA)
// Brief    : Bit-serial WIDTH-bit unsigned adder, {Cout,Sum} = A + B + Cin,
//            one bit per clock LSB-first, carry held in a flip-flop.
// Revision : 1.0 - initial release
// ============================================================================

// Single-bit full adder used as the serial datapath core.
module FA (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             SYSCLK,
  input  logic             NSYSRESET,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  // Bit counter needs at least one bit, even for WIDTH=1.
  localparam int            CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic             fa_sum, fa_cout;

  FA u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  // New sum bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_one
      assign res_next = fa_sum;
    end else begin : g_res_multi
      assign res_next = {fa_sum, res_sr[WIDTH-1:1]};
    end
  endgenerate

  // State register; reset abandons any operation in flight.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) state <= ST_IDLE;
    else            state <= state_next;
  end

  // Next-state and status outputs; start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: begin
        busy = 1'b1;
        if (count == CNT_LAST) state_next = ST_DONE;
      end
      ST_DONE:  begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Operand capture, serial add and result publication.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      Sum    <= '0;
      Cout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            carry  <= Cin;
            count  <= '0;
            res_sr <= '0;
          end
        end
        ST_SHIFT: begin
          res_sr <= res_next;
          carry  <= fa_cout;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          // Hold at the last index so the counter never wraps.
          if (count != CNT_LAST) count <= count + 1'b1;
        end
        ST_DONE: begin
          Sum  <= res_sr;
          Cout <= carry;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
